vga_rx_monitor: RTL



---
 rtl/vga_rx_monitor.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers raster position from hsync/vsync, checks frame timing,
// tracks lock, re-emits active pixels with coordinates and captures one probe pixel per frame.
module vga_rx_monitor #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 521,
  parameter int H_PULSE = 96,
  parameter int V_PULSE = 2,
  parameter int H_BP    = 144,
  parameter int H_FP    = 784,
  parameter int V_BP    = 31,
  parameter int V_FP    = 511
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic [11:0] probe_rgb,
  output logic        probe_hit,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_PLAST = 10'(H_PULSE - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_PLAST = 10'(V_PULSE - 1);
  localparam logic [9:0] H_BP_W  = 10'(H_BP);
  localparam logic [9:0] H_FP_W  = 10'(H_FP);
  localparam logic [9:0] V_BP_W  = 10'(V_BP);
  localparam logic [9:0] V_FP_W  = 10'(V_FP);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state_r;
  logic        hs_r, vs_r, acq_err_r, hit_done_r;
  logic [11:0] rgb_r;
  logic [9:0]  hcnt_r, vcnt_r;
  logic        ls_s, fs_s, hs_rise_s, vs_rise_s, vs_fall_s, bad_s, err_s, act_s, match_s;
  logic [9:0]  col_s, row_s;

  // Sync edge detection, timing checks and active-area decode on the registered sample.
  always_comb begin
    ls_s      = hs_r & ~hsync;
    fs_s      = ls_s & vs_r & ~vsync;
    hs_rise_s = ~hs_r & hsync;
    vs_rise_s = ~vs_r & vsync;
    vs_fall_s = vs_r & ~vsync;
    bad_s     = (ls_s && (hcnt_r != H_LAST)) ||
                (hs_rise_s && (hcnt_r != H_PLAST)) ||
                (fs_s && (vcnt_r != V_LAST)) ||
                (vs_rise_s && !(ls_s && (vcnt_r == V_PLAST))) ||
                (vs_fall_s && !ls_s);
    err_s     = bad_s && (state_r != UNLOCKED);
    col_s     = hcnt_r - H_BP_W;
    row_s     = vcnt_r - V_BP_W;
    act_s     = (state_r == LOCKED) &&
                (hcnt_r >= H_BP_W) && (hcnt_r < H_FP_W) &&
                (vcnt_r >= V_BP_W) && (vcnt_r < V_FP_W);
    match_s   = act_s && !hit_done_r && (col_s == probe_x) && (row_s == probe_y);
  end

  // Input stage plus position counters; counters saturate so a dead sync cannot wrap.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      hs_r   <= 1'b1;
      vs_r   <= 1'b1;
      rgb_r  <= 12'h000;
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      rgb_r <= {red, green, blue};
      if (ls_s) begin
        hcnt_r <= 10'd0;
      end else if (hcnt_r != CNT_MAX) begin
        hcnt_r <= hcnt_r + 10'd1;
      end else begin
        hcnt_r <= hcnt_r;
      end
      if (fs_s) begin
        vcnt_r <= 10'd0;
      end else if (ls_s && (vcnt_r != CNT_MAX)) begin
        vcnt_r <= vcnt_r + 10'd1;
      end else begin
        vcnt_r <= vcnt_r;
      end
    end
  end

  // Lock FSM; an error on the closing FS of an acquire frame also forces another acquire frame.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      state_r   <= UNLOCKED;
      acq_err_r <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state_r)
        UNLOCKED: begin
          locked <= 1'b0;
          if (fs_s) begin
            state_r   <= ACQUIRE;
            acq_err_r <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (fs_s) begin
            acq_err_r <= 1'b0;
            if (!acq_err_r && !err_s) begin
              state_r <= LOCKED;
              locked  <= 1'b1;
            end else begin
              locked <= 1'b0;
            end
          end else begin
            acq_err_r <= acq_err_r | err_s;
            locked    <= 1'b0;
          end
        end
        LOCKED: begin
          if (err_s) begin
            state_r <= UNLOCKED;
            locked  <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end
        default: begin
          state_r   <= UNLOCKED;
          acq_err_r <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  // Error counter and frame-start pulse.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      err_cnt     <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fs_s;
      if (err_s && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

  // Pixel stream and probe capture; pixel fields hold while pix_valid is low.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_rgb    <= 12'h000;
      probe_rgb  <= 12'h000;
      probe_hit  <= 1'b0;
      hit_done_r <= 1'b0;
    end else begin
      pix_valid <= act_s;
      probe_hit <= match_s;
      if (act_s) begin
        pix_x   <= col_s;
        pix_y   <= row_s;
        pix_rgb <= rgb_r;
      end
      if (match_s) begin
        probe_rgb <= rgb_r;
      end
      if (fs_s) begin
        hit_done_r <= 1'b0;
      end else if (match_s) begin
        hit_done_r <= 1'b1;
      end else begin
        hit_done_r <= hit_done_r;
      end
    end
  end

endmodule
